// File: rtl/aes_key_pkg.sv
// Shared types and byte/word helpers for the AES-128 key schedule.
// The S-box is computed as GF(2^8) inversion followed by the AES affine map.
package aes_key_pkg;

   localparam int NR_AES128 = 10;

   typedef logic [31:0]  aes_word_t;
   typedef logic [127:0] aes_key_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      STREAM = 2'd2
   } ks_state_e;

   function automatic aes_word_t rcon(logic [3:0] r);
      logic [7:0] rc;
      case (r)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return {rc, 24'h000000};
   endfunction

   function automatic aes_word_t rot_word(aes_word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse is x^254 by an addition chain; zero maps to zero as AES requires.
   function automatic logic [7:0] sbox(logic [7:0] x);
      logic [7:0] x3, x7, x15, x31, x63, x127, inv;
      x3   = gf_mul(gf_mul(x, x), x);
      x7   = gf_mul(gf_mul(x3, x3), x);
      x15  = gf_mul(gf_mul(x7, x7), x);
      x31  = gf_mul(gf_mul(x15, x15), x);
      x63  = gf_mul(gf_mul(x31, x31), x);
      x127 = gf_mul(gf_mul(x63, x63), x);
      inv  = gf_mul(x127, x127);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One backward round of the AES-128 key expansion (round r key -> round r-1 key).
// With AES_FWD_EXPAND_EN the same S-box word also serves the forward step.
module aes_sub_word
   import aes_key_pkg::*;
(
   input  aes_word_t din,
   output aes_word_t dout
);

   assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

module aes_inv_key_step
   import aes_key_pkg::*;
(
   input  aes_key_t   next_key,
   input  logic [3:0] round,
`ifdef AES_FWD_EXPAND_EN
   input  logic       fwd,
   output aes_key_t   fwd_key,
`endif
   output aes_key_t   prev_key
);

   aes_word_t n0, n1, n2, n3;
   aes_word_t p0, p1, p2, p3;
   aes_word_t sw_in, sw_out;

   assign {n0, n1, n2, n3} = next_key;

   // Words 1..3 of the previous key fall out of XORs alone; word 0 needs p3 first.
   assign p3 = n3 ^ n2;
   assign p2 = n2 ^ n1;
   assign p1 = n1 ^ n0;

`ifdef AES_FWD_EXPAND_EN
   aes_word_t f0, f1, f2, f3;

   assign sw_in   = fwd ? rot_word(n3) : rot_word(p3);
   assign f0      = n0 ^ sw_out ^ rcon(round);
   assign f1      = n1 ^ f0;
   assign f2      = n2 ^ f1;
   assign f3      = n3 ^ f2;
   assign fwd_key = {f0, f1, f2, f3};
`else
   assign sw_in = rot_word(p3);
`endif

   aes_sub_word u_sub_word (
      .din  (sw_in),
      .dout (sw_out)
   );

   assign p0       = n0 ^ sw_out ^ rcon(round);
   assign prev_key = {p0, p1, p2, p3};

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: streams round keys 10..0 over a valid/ready port.
// Define AES_FWD_EXPAND_EN to accept the cipher key and expand forward internally first.
module aes_inv_key_sched
   import aes_key_pkg::*;
#(
   parameter int NR    = NR_AES128,
   parameter int KEY_W = 128
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [KEY_W-1:0] key_in,
   input  logic             key_valid,
   output logic             key_ready,
   output logic [KEY_W-1:0] rk_out,
   output logic [3:0]       rk_round,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic             rk_last,
   output logic             busy
);

   // Handshake: a key transfers on a rising edge where valid && ready are both high;
   // once rk_valid rises, rk_out/rk_round stay frozen until that transfer happens.

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   ks_state_e  state, state_nxt;
   aes_key_t   rk_q;
   logic [3:0] round_q;
   logic [3:0] step_round;
   aes_key_t   prev_key;

`ifdef AES_FWD_EXPAND_EN
   aes_key_t fwd_key;
   // Forward step builds round_q+1, so its Rcon index runs one ahead.
   assign step_round = (state == EXPAND) ? round_q + 4'd1 : round_q;
`else
   assign step_round = round_q;
`endif

   aes_inv_key_step u_step (
      .next_key (rk_q),
      .round    (step_round),
`ifdef AES_FWD_EXPAND_EN
      .fwd      (state == EXPAND),
      .fwd_key  (fwd_key),
`endif
      .prev_key (prev_key)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
`ifdef AES_FWD_EXPAND_EN
            if (key_valid) state_nxt = EXPAND;
`else
            if (key_valid) state_nxt = STREAM;
`endif
         end
`ifdef AES_FWD_EXPAND_EN
         EXPAND: begin
            if (round_q == LAST_ROUND - 4'd1) state_nxt = STREAM;
         end
`endif
         STREAM: begin
            if (rk_ready && round_q == 4'd0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      key_ready = 1'b0;
      busy      = 1'b1;
      rk_valid  = 1'b0;
      rk_last   = 1'b0;
      if (state == IDLE) begin
         key_ready = 1'b1;
         busy      = 1'b0;
      end
      if (state == STREAM) begin
         rk_valid = 1'b1;
         rk_last  = (round_q == 4'd0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rk_q    <= '0;
         round_q <= 4'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (key_valid) begin
                  rk_q <= key_in;
`ifdef AES_FWD_EXPAND_EN
                  round_q <= 4'd0;
`else
                  round_q <= LAST_ROUND;
`endif
               end
            end
`ifdef AES_FWD_EXPAND_EN
            EXPAND: begin
               rk_q    <= fwd_key;
               round_q <= round_q + 4'd1;
            end
`endif
            STREAM: begin
               if (rk_ready && round_q != 4'd0) begin
                  rk_q    <= prev_key;
                  round_q <= round_q - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rk_out   = rk_q;
   assign rk_round = round_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: forward-expansion reference model feeds a scoreboard
// that a negedge monitor drains on every presented round key.
module tb_aes_inv_key_sched;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [127:0] key_in = '0;
   logic         key_valid = 1'b0;
   logic         key_ready;
   logic [127:0] rk_out;
   logic [3:0]   rk_round;
   logic         rk_valid;
   logic         rk_ready = 1'b1;
   logic         rk_last;
   logic         busy;

   int           n_checks = 0;
   int           n_errors = 0;
   int           cyc = 0;
   int           hs0_edge = -1;
   int           acc_edge = -1;
   bit           rand_ready = 1'b0;
   logic [131:0] exp_q[$];
   logic [127:0] got[0:15];
   logic [7:0]   sbox_tab[0:255];

   aes_inv_key_sched dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_in    (key_in),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .rk_out    (rk_out),
      .rk_round  (rk_round),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk_last   (rk_last),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] r, x, y;
      r = 8'h00; x = a; y = b;
      while (y != 8'h00) begin
         if (y[0]) r = r ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return r;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int b = 0; b < 8; b++)
            s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8]
                   ^ inv[(b + 7) % 8] ^ c[b];
         sbox_tab[x] = s;
      end
   endtask

   task automatic expand(input logic [127:0] key, output logic [127:0] ks [0:10]);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                 ^ {rc, 24'h000000};
            rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
         end
         w[i] = w[i - 4] ^ t;
      end
      for (int r = 0; r < 11; r++) ks[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- drivers ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send_key(input logic [127:0] cipher);
      logic [127:0] ks [0:10];
      bit           accepted;
      int           budget;
      expand(cipher, ks);
      key_in    = ks[10];
      key_valid = 1'b1;
      accepted  = 1'b0;
      budget    = 0;
      while (!accepted && budget < 200) begin
         if (key_ready) begin
            accepted = 1'b1;
            acc_edge = cyc + 1;
            for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), ks[r]});
         end
         @(posedge clk);
         #1;
         budget++;
      end
      key_valid = 1'b0;
      if (!accepted) begin
         n_checks++;
         n_errors++;
         $display("FAIL key_accept: key_ready never seen high within %0d cycles", budget);
      end
   endtask

   task automatic wait_idle();
      int budget;
      budget = 0;
      while ((exp_q.size() != 0 || busy) && budget < 2000) begin
         @(posedge clk);
         #1;
         budget++;
      end
      n_checks++;
      if (exp_q.size() != 0 || busy) begin
         n_errors++;
         $display("FAIL drain: %0d keys outstanding, busy=%b", exp_q.size(), busy);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [131:0] e;
      forever begin
         @(negedge clk);
         if (reset_n && rk_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_rk: round %0d key %h with empty queue", rk_round, rk_out);
            end else begin
               e = exp_q[0];
               check("rk_out", rk_out, e[127:0]);
               check("rk_round", 128'(rk_round), 128'(e[131:128]));
               check("rk_last", 128'(rk_last), 128'(e[131:128] == 4'd0));
               if (rk_ready) begin
                  void'(exp_q.pop_front());
                  got[rk_round] = rk_out;
                  if (rk_round == 4'd0) hs0_edge = cyc + 1;
               end
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int budget;
      logic [127:0] ka, kb;
      build_sbox();
      repeat (3) @(posedge clk);
      #1;
      check("reset_key_ready", 128'(key_ready), 128'(1));
      check("reset_rk_valid", 128'(rk_valid), 128'(0));
      check("reset_rk_last", 128'(rk_last), 128'(0));
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_rk_out", rk_out, 128'(0));
      check("reset_rk_round", 128'(rk_round), 128'(0));
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // FIPS-197 vector, consumer always ready
      send_key(FIPS_KEY);
      wait_idle();
      check("fips_r10", got[10], FIPS_R10);
      check("fips_r9", got[9], FIPS_R9);
      check("fips_r1", got[1], FIPS_R1);
      check("fips_r0", got[0], FIPS_KEY);

      // Same vector with random back-pressure
      for (int i = 0; i < 16; i++) got[i] = '0;
      rand_ready = 1'b1;
      send_key(FIPS_KEY);
      wait_idle();
      check("stall_r9", got[9], FIPS_R9);
      check("stall_r0", got[0], FIPS_KEY);

      // Random keys, issued back to back under random back-pressure
      repeat (4) send_key({$urandom, $urandom, $urandom, $urandom});
      wait_idle();

      // Key offered during a stream is ignored; it lands right after the round-0 handshake
      rand_ready = 1'b0;
      @(posedge clk);
      #1;
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      send_key(ka);
      check("stream_key_ready", 128'(key_ready), 128'(0));
      check("stream_busy", 128'(busy), 128'(1));
      check("stream_first_round", 128'(rk_round), 128'(10));
      send_key(kb);
      check("back_to_back_edge", 128'(acc_edge), 128'(hs0_edge + 1));
      wait_idle();

      // Reset in the middle of a stream
      rand_ready = 1'b1;
      send_key({$urandom, $urandom, $urandom, $urandom});
      budget = 0;
      while (!(rk_valid && rk_round == 4'd5) && budget < 300) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check("reach_round5", 128'(rk_valid && rk_round == 4'd5), 128'(1));
      reset_n = 1'b0;
      #1;
      check("midreset_rk_valid", 128'(rk_valid), 128'(0));
      check("midreset_busy", 128'(busy), 128'(0));
      check("midreset_key_ready", 128'(key_ready), 128'(1));
      check("midreset_rk_round", 128'(rk_round), 128'(0));
      exp_q.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      send_key({$urandom, $urandom, $urandom, $urandom});
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
